// File: rtl/serial_servo_pkg.sv
// Shared definitions for the serial servo link: frame format and the
// receive control unit state encodings (values double as db_estado codes).
package serial_servo_pkg;

    localparam int unsigned DATA_BITS   = 7;
    localparam int unsigned PARITY_EVEN = 1;

    typedef enum logic [3:0] {
        S_INICIAL      = 4'h0,
        S_INICIO       = 4'h1,
        S_DADOS        = 4'h3,
        S_PARIDADE     = 4'h7,
        S_PARADA       = 4'hF,
        S_ARMAZENA     = 4'h5,
        S_ESPERA_LINHA = 4'hE
    } rx_state_e;

    localparam logic [3:0] DB_INVALIDO = 4'hD;

    // Raw fields captured while a frame is being shifted in
    typedef struct packed {
        logic [DATA_BITS-1:0] dado;
        logic                 paridade;
        logic                 parada;
    } rx_frame_t;

    function automatic logic [3:0] state_code(input rx_state_e s);
        case (s)
            S_INICIAL, S_INICIO, S_DADOS, S_PARIDADE,
            S_PARADA, S_ARMAZENA, S_ESPERA_LINHA: return 4'(s);
            default:                              return DB_INVALIDO;
        endcase
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period down-counter: load a value, get a one-cycle expiry pulse
// exactly load_val cycles after the load edge. Load values must be >= 1.
module rx_bit_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic         expire_q;

    // Counter parks at zero; the pulse is registered off the 1 -> 0 step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            expire_q <= !load_i && (cnt_q == W'(1));
            if (load_i) begin
                cnt_q <= load_val_i;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/serial_servo_rx_uc.sv
// 7E1 asynchronous serial receiver with embedded Moore control unit and a
// tem_dado / recebe_dado handshake toward the command decoder.
module serial_servo_rx_uc
    import serial_servo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 recebe_dado,
    output logic [DATA_BITS-1:0] dado_recebido,
    output logic                 tem_dado,
    output logic                 fim_rx,
    output logic                 paridade_ok,
    output logic                 erro_framing,
    output logic                 overrun,
    output logic [3:0]           db_estado
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 rx_meta_q, rx_s_q;
    rx_state_e            state_q, state_d;
    rx_frame_t            frame_q, frame_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] dado_q, dado_d;
    logic                 tem_q, tem_d;
    logic                 fim_q, fim_d;
    logic                 pok_q, pok_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic [3:0]           db_q, db_d;

    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_exp;

    rx_bit_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clock),
        .rst_n      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    // Line synchroniser presets to idle so reset never looks like a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_INICIAL;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            dado_q    <= '0;
            tem_q     <= 1'b0;
            fim_q     <= 1'b0;
            pok_q     <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            db_q      <= 4'h0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            dado_q    <= dado_d;
            tem_q     <= tem_d;
            fim_q     <= fim_d;
            pok_q     <= pok_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            db_q      <= db_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        dado_d    = dado_q;
        tem_d     = tem_q;
        pok_d     = pok_q;
        fe_d      = fe_q;
        ovr_d     = ovr_q;
        tmr_load  = 1'b0;
        tmr_val   = TW'(CLKS_PER_BIT - 1);

        if (recebe_dado) begin
            tem_d = 1'b0;
        end

        case (state_q)
            S_INICIAL: begin
                if (!rx_s_q) begin
                    state_d  = S_INICIO;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(CLKS_PER_BIT / 2 - 1);
                end
            end
            S_INICIO: begin
                if (tmr_exp) begin
                    if (!rx_s_q) begin
                        state_d   = S_DADOS;
                        tmr_load  = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_INICIAL;
                    end
                end
            end
            S_DADOS: begin
                if (tmr_exp) begin
                    // LSB arrives first, so shift in at the top
                    frame_d.dado = {rx_s_q, frame_q.dado[DATA_BITS-1:1]};
                    bit_cnt_d    = bit_cnt_q + 1'b1;
                    tmr_load     = 1'b1;
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d = S_PARIDADE;
                    end
                end
            end
            S_PARIDADE: begin
                if (tmr_exp) begin
                    frame_d.paridade = rx_s_q;
                    tmr_load         = 1'b1;
                    state_d          = S_PARADA;
                end
            end
            S_PARADA: begin
                if (tmr_exp) begin
                    frame_d.parada = rx_s_q;
                    state_d        = S_ARMAZENA;
                end
            end
            S_ARMAZENA: begin
                dado_d = frame_q.dado;
                pok_d  = ((^frame_q.dado) ^ frame_q.paridade) == ~1'(PARITY_EVEN);
                fe_d   = ~frame_q.parada;
                if (tem_q && !recebe_dado) begin
                    ovr_d = 1'b1;
                end
                tem_d   = 1'b1;
                state_d = frame_q.parada ? S_INICIAL : S_ESPERA_LINHA;
            end
            S_ESPERA_LINHA: begin
                if (rx_s_q) begin
                    state_d = S_INICIAL;
                end
            end
            default: begin
                state_d = S_INICIAL;
            end
        endcase

        fim_d = (state_d == S_ARMAZENA);
        db_d  = state_code(state_d);
    end

    assign dado_recebido = dado_q;
    assign tem_dado      = tem_q;
    assign fim_rx        = fim_q;
    assign paridade_ok   = pok_q;
    assign erro_framing  = fe_q;
    assign overrun       = ovr_q;
    assign db_estado     = db_q;

endmodule

// File: tb/tb_serial_servo_rx_uc.sv
// Bench for serial_servo_rx_uc at 8 clocks per bit: vector table, corner
// sequences and randomized frames against a frame-level reference model.
module tb_serial_servo_rx_uc;

    localparam int unsigned CPB = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       recebe_dado;
    logic [6:0] dado_recebido;
    logic       tem_dado, fim_rx, paridade_ok, erro_framing, overrun;
    logic [3:0] db_estado;

    serial_servo_rx_uc #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .recebe_dado   (recebe_dado),
        .dado_recebido (dado_recebido),
        .tem_dado      (tem_dado),
        .fim_rx        (fim_rx),
        .paridade_ok   (paridade_ok),
        .erro_framing  (erro_framing),
        .overrun       (overrun),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] d;
        logic       par, stp, ack_b, ack_s;
        logic [6:0] e_d;
        logic       e_pok, e_fe, e_tem, e_ovr;
    } vec_t;

    vec_t tab[8];

    int total, bad, cyc, fim_cnt, fim_cyc, seq_len;
    logic [31:0] seq_w;
    logic [3:0]  last_db;
    logic        ack_store;

    logic [6:0] m_data;
    logic       m_pok, m_fe, m_tem, m_ovr;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs
    task automatic tick(input logic rx_v, input logic ack_v);
        @(negedge clock);
        cyc++;
        if (fim_rx) begin
            fim_cnt++;
            fim_cyc = cyc;
        end
        if (db_estado != last_db) begin
            seq_w   = (seq_w << 4) | 32'(db_estado);
            seq_len++;
            last_db = db_estado;
        end
        rx          = rx_v;
        recebe_dado = ack_v || (ack_store && db_estado == 4'h5);
    endtask

    task automatic seq_start();
        seq_w   = 32'(db_estado);
        seq_len = 1;
        last_db = db_estado;
        fim_cnt = 0;
    endtask

    function automatic longint seq_val();
        return (longint'(seq_len) << 32) | longint'(seq_w);
    endfunction

    function automatic longint seq_exp(input logic stp);
        return stp ? ((64'd7 << 32) | 64'h0137F50) : ((64'd8 << 32) | 64'h137F5E0);
    endfunction

    task automatic send_frame(input logic [6:0] d, input logic par, input logic stp,
                              output int t0);
        logic [9:0] bits;
        bits = {stp, par, d, 1'b0};
        seq_start();
        t0 = cyc + 1;
        for (int b = 0; b < 10; b++)
            for (int j = 0; j < int'(CPB); j++) tick(bits[b], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0);
    endtask

    task automatic ack();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        m_tem = 1'b0;
    endtask

    // Frame-level model of what the receiver must report after a frame
    task automatic model_frame(input logic [6:0] d, input logic par, input logic stp,
                               input logic ackst);
        if (m_tem && !ackst) m_ovr = 1'b1;
        m_tem  = 1'b1;
        m_data = d;
        m_pok  = (((^d) ^ par) == 1'b0);
        m_fe   = !stp;
    endtask

    task automatic model_reset();
        m_data = '0; m_pok = 0; m_fe = 0; m_tem = 0; m_ovr = 0;
    endtask

    task automatic check_lat(input string tag, input int t0);
        int lat;
        lat = fim_cyc - t0;
        total++;
        if (lat < 78 || lat > 80) begin
            bad++;
            $display("FAIL %s.latency actual=%0d required=78..80", tag, lat);
        end
    endtask

    task automatic check_model(input string tag, input int t0, input logic stp);
        chk({tag, ".dado"}, longint'(dado_recebido), longint'(m_data));
        chk({tag, ".pok"},  longint'(paridade_ok),   longint'(m_pok));
        chk({tag, ".fe"},   longint'(erro_framing),  longint'(m_fe));
        chk({tag, ".tem"},  longint'(tem_dado),      longint'(m_tem));
        chk({tag, ".ovr"},  longint'(overrun),       longint'(m_ovr));
        chk({tag, ".fim"},  longint'(fim_cnt),       64'd1);
        chk({tag, ".seq"},  seq_val(),               seq_exp(stp));
        check_lat(tag, t0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".dado"}, longint'(dado_recebido), 0);
        chk({tag, ".tem"},  longint'(tem_dado),      0);
        chk({tag, ".fim"},  longint'(fim_rx),        0);
        chk({tag, ".pok"},  longint'(paridade_ok),   0);
        chk({tag, ".fe"},   longint'(erro_framing),  0);
        chk({tag, ".ovr"},  longint'(overrun),       0);
        chk({tag, ".db"},   longint'(db_estado),     0);
    endtask

    initial begin
        int t0;
        logic [6:0] d;
        logic par, stp, ackst;

        total = 0; bad = 0; cyc = 0; fim_cnt = 0; fim_cyc = 0;
        ack_store = 1'b0; rx = 1'b1; recebe_dado = 1'b0; reset = 1'b1;
        seq_w = '0; seq_len = 0; last_db = '0;
        model_reset();

        //             d      par  stp  ackb acks  e_d    pok  fe   tem  ovr
        tab[0] = '{7'h35, 1'b0, 1'b1, 1'b0, 1'b0, 7'h35, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[1] = '{7'h35, 1'b1, 1'b1, 1'b1, 1'b0, 7'h35, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[2] = '{7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[3] = '{7'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[4] = '{7'h2A, 1'b1, 1'b0, 1'b1, 1'b0, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[5] = '{7'h01, 1'b0, 1'b1, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[6] = '{7'h11, 1'b0, 1'b1, 1'b1, 1'b0, 7'h11, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[7] = '{7'h22, 1'b0, 1'b1, 1'b0, 1'b0, 7'h22, 1'b1, 1'b0, 1'b1, 1'b1};

        idle(2);
        reset = 1'b0;
        idle(3);
        check_zero("reset");
        reset = 1'b1;
        idle(4);

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (tab[i].ack_b) ack();
            ack_store = tab[i].ack_s;
            model_frame(tab[i].d, tab[i].par, tab[i].stp, tab[i].ack_s);
            send_frame(tab[i].d, tab[i].par, tab[i].stp, t0);
            idle(4);
            ack_store = 1'b0;
            chk({tag, ".dado"}, longint'(dado_recebido), longint'(tab[i].e_d));
            chk({tag, ".pok"},  longint'(paridade_ok),   longint'(tab[i].e_pok));
            chk({tag, ".fe"},   longint'(erro_framing),  longint'(tab[i].e_fe));
            chk({tag, ".tem"},  longint'(tem_dado),      longint'(tab[i].e_tem));
            chk({tag, ".ovr"},  longint'(overrun),       longint'(tab[i].e_ovr));
            chk({tag, ".fim"},  longint'(fim_cnt),       64'd1);
            chk({tag, ".seq"},  seq_val(),               seq_exp(tab[i].stp));
            check_lat(tag, t0);
        end

        // Break after a bad stop bit must park in espera_linha
        ack();
        model_frame(7'h41, 1'b0, 1'b0, 1'b0);
        send_frame(7'h41, 1'b0, 1'b0, t0);
        for (int k = 0; k < 40; k++) tick(1'b0, 1'b0);
        chk("brk.db_low", longint'(db_estado),    64'hE);
        chk("brk.fe",     longint'(erro_framing), 64'd1);
        chk("brk.dado",   longint'(dado_recebido), 64'h41);
        idle(4);
        chk("brk.db_idle", longint'(db_estado), 64'h0);
        chk("brk.fim",     longint'(fim_cnt),   64'd1);

        // Short low glitch on idle line is rejected at the mid-start sample
        seq_start();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        idle(10);
        chk("glitch.fim",  longint'(fim_cnt), 0);
        chk("glitch.seq",  seq_val(), (64'd3 << 32) | 64'h010);
        chk("glitch.dado", longint'(dado_recebido), longint'(m_data));
        chk("glitch.tem",  longint'(tem_dado),      longint'(m_tem));
        chk("glitch.fe",   longint'(erro_framing),  longint'(m_fe));

        // Ack coinciding with armazena: new byte kept, no overrun
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        model_reset();
        idle(3);
        model_frame(7'h11, 1'b0, 1'b1, 1'b0);
        send_frame(7'h11, 1'b0, 1'b1, t0);
        idle(4);
        ack_store = 1'b1;
        model_frame(7'h22, 1'b0, 1'b1, 1'b1);
        send_frame(7'h22, 1'b0, 1'b1, t0);
        idle(4);
        ack_store = 1'b0;
        chk("ackst.ovr",  longint'(overrun),       0);
        chk("ackst.tem",  longint'(tem_dado),      1);
        chk("ackst.dado", longint'(dado_recebido), 64'h22);

        // Reset in the middle of the data bits
        for (int k = 0; k < int'(CPB); k++) tick(1'b0, 1'b0);
        for (int k = 0; k < 3 * int'(CPB) + 3; k++) tick(1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check_zero("midrst");
        idle(3);
        reset = 1'b1;
        model_reset();
        idle(3);
        model_frame(7'h7F, 1'b1, 1'b1, 1'b0);
        send_frame(7'h7F, 1'b1, 1'b1, t0);
        idle(4);
        check_model("after_rst", t0, 1'b1);

        // Randomized frames against the reference model
        for (int i = 0; i < 24; i++) begin
            d     = 7'($urandom);
            par   = (^d) ^ ($urandom_range(3) == 0);
            stp   = ($urandom_range(9) != 0);
            ackst = ($urandom_range(3) == 0);
            if ($urandom_range(1) == 1) ack();
            idle(int'($urandom_range(6)));
            ack_store = ackst;
            model_frame(d, par, stp, ackst);
            send_frame(d, par, stp, t0);
            idle(4);
            ack_store = 1'b0;
            check_model($sformatf("rnd%0d", i), t0, stp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_servo_rx_uc.md
Name: serial_servo_rx_uc

Overview:
- Receive side of the serial servo test link: a 7E1 asynchronous serial receiver with an embedded Moore control unit.
- Deserialises the RX line into a 7-bit data byte and checks even parity and the stop bit.
- Emits `fim_rx`, a one-cycle pulse the transmit-side control unit consumes to leave its wait state.
- Holds the received byte behind a `tem_dado` / `recebe_dado` handshake toward the command decoder.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); must be >= 4.
- DATA_BITS, 7, data bits per frame, sent LSB first.
- PARITY_EVEN, 1, 1 = even parity, 0 = odd parity.

Ports:
- clock  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clock.
- recebe_dado  input  1  one-cycle pulse from the consumer acknowledging the held byte.
- dado_recebido  output  DATA_BITS  last received data byte.
- tem_dado  output  1  level; a byte is held and not yet acknowledged.
- fim_rx  output  1  one-cycle pulse when a frame completes (good or bad).
- paridade_ok  output  1  parity result of the last frame.
- erro_framing  output  1  stop bit of the last frame was sampled as 0.
- overrun  output  1  sticky; a byte was overwritten while unacknowledged.
- db_estado  output  4  current state code, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state goes to inicial and every output is 0.
  - The rx synchroniser flops preset to 1.
  - Reset mid-frame discards the partial frame.
- rx passes through a 2-FF synchroniser; all sampling uses the synchronised value rx_s.
- States and db_estado codes:
  - inicial 0x0: wait for rx_s=0, then go to inicio and load the timer with CLKS_PER_BIT/2-1.
  - inicio 0x1: on timer expiry sample rx_s.
    - rx_s=0: go to dados, load the timer with CLKS_PER_BIT-1, clear the bit counter.
    - rx_s=1: glitch; return to inicial with no outputs changed.
  - dados 0x3: on each expiry shift rx_s in at the MSB (LSB-first reassembly), increment the bit counter, reload the timer.
    - After DATA_BITS samples, go to paridade.
  - paridade 0x7: on expiry sample the parity bit and go to parada.
  - parada 0xF: on expiry sample the stop bit and go to armazena.
  - armazena 0x5: single cycle.
    - Load dado_recebido.
    - paridade_ok = (XOR of data bits XOR parity bit) == ~PARITY_EVEN.
    - erro_framing = ~stop.
    - Assert fim_rx.
    - Next state: espera_linha if stop=0, else inicial.
  - espera_linha 0xE: wait for rx_s=1, then go to inicial. This blocks a held-low break from retriggering reception.
  - Unused encodings go to inicial; db_estado shows 0xD.
- Sampling timing:
  - The start bit is sampled at mid-bit.
  - Each later bit is sampled exactly CLKS_PER_BIT cycles after the previous sample.
  - Latency from the rx falling edge at the pin to fim_rx = 2 + CLKS_PER_BIT/2 + (DATA_BITS+2)*CLKS_PER_BIT + 1 cycles, ±1 for edge phase.
- Handshake:
  - tem_dado is set in armazena.
  - recebe_dado clears tem_dado on the next edge; recebe_dado with tem_dado=0 is ignored.
  - armazena with tem_dado=1 and no recebe_dado that cycle: overwrite dado_recebido and set overrun.
  - armazena together with recebe_dado: the new byte wins, tem_dado stays 1, overrun is unchanged.
- overrun clears only on reset.
- paridade_ok and erro_framing hold until the next armazena.
- A frame with a parity or framing error still sets tem_dado; the consumer checks the flags.
- rx activity during armazena is ignored; a new start bit is detected in inicial on the following cycle.

Decomposition:
- Shared package serial_servo_pkg holds:
  - State encodings (inicial, inicio, dados, paridade, parada, armazena, espera_linha) and their db_estado values.
  - The frame constants DATA_BITS=7 and PARITY_EVEN=1, shared with the transmit side.
- One sub-module: rx_bit_timer, a down-counter with load value, load strobe and expiry pulse.
- The FSM, shift register and flags stay in the top level.

Test Plan (CLKS_PER_BIT=8):
- Send 0x35 with parity 0 and stop 1 → one fim_rx pulse, dado_recebido=0x35, paridade_ok=1, erro_framing=0, tem_dado=1, db_estado sequence 0,1,3,7,F,5,0.
- Send 0x35 with parity 1 → dado_recebido=0x35, paridade_ok=0, tem_dado=1.
- Send 0x41 with stop 0, then hold rx low 40 cycles → erro_framing=1, state stays 0xE until rx rises, no second fim_rx.
- Drive a 2-cycle low glitch on idle rx → returns to inicial, no fim_rx, outputs unchanged.
- Receive 0x11, no ack, then receive 0x22 → dado_recebido=0x22, overrun=1. Repeat after reset with recebe_dado pulsed in the armazena cycle → overrun=0, tem_dado=1.
- Assert reset=0 midway through the data bits → all outputs 0 immediately, db_estado=0. After release, a clean 0x7F frame is received correctly.
